energy_sample_collector: RTL and testbench

//  Producer side of the energy monitor's max-finder vector interface: gathers a serial

---
 rtl/energy_monitor_pkg.sv | 17 +
 rtl/energy_vec_slot.sv | 62 ++++++
 rtl/energy_sample_collector.sv | 146 ++++++++++++++
 tb/tb_energy_sample_collector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/energy_monitor_pkg.sv
// Shared types and helpers for the energy monitor's max-finder vector interface.
package energy_monitor_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } collector_state_e;

    localparam int unsigned SAMPLE_W = 64;
    typedef logic [SAMPLE_W-1:0] sample_t;

    // Width needed to hold a fill count in the range 0..n.
    function automatic int unsigned fill_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/energy_vec_slot.sv
// One-entry valid/ready output register holding an N-lane vector and its fill count.
module energy_vec_slot #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATAW  = 64,
    parameter int unsigned FILL_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [DATAW-1:0]  data_i [N-1:0],
    input  logic [FILL_W-1:0] fill_i,
    output logic              valid_o,
    output logic [DATAW-1:0]  data_o [N-1:0],
    output logic [FILL_W-1:0] fill_o
);

    logic              valid_q, valid_d;
    logic [DATAW-1:0]  data_q [N-1:0];
    logic [DATAW-1:0]  data_d [N-1:0];
    logic [FILL_W-1:0] fill_q, fill_d;

    // Clear drops the entry but leaves stale data; a load wins over a drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        fill_d  = fill_q;
        if (clear_i) begin
            valid_d = 1'b0;
            fill_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            fill_d  = fill_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            fill_q  <= '0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign fill_o  = fill_q;

endmodule

// File: rtl/energy_sample_collector.sv
// Gathers a serial energy-sample stream into N-wide vectors for the max-finder,
// double-buffered so the stream keeps running while a vector waits downstream.
module energy_sample_collector
    import energy_monitor_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DATAW = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic                     flush_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [DATAW-1:0]         s_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [DATAW-1:0]         m_data_o [N-1:0],
    output logic [fill_w(N)-1:0]     m_fill_o
);

    localparam int unsigned CNT_W  = $clog2(N);
    localparam int unsigned FILL_W = fill_w(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    collector_state_e  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FILL_W-1:0] hold_q, hold_d;
    logic [DATAW-1:0]  buf_q [N-1:0];
    logic [DATAW-1:0]  buf_d [N-1:0];
    logic [DATAW-1:0]  vec_s [N-1:0];
    logic [DATAW-1:0]  load_data_s [N-1:0];
    logic [FILL_W-1:0] k_s, load_fill_s;
    logic              active_s, accept_s, slot_free_s, close_s, load_s, drain_s;

    assign active_s    = en_i && !clear_i;
    assign s_ready_o   = active_s && (state_q == FILL) && !rst_i;
    assign accept_s    = s_valid_i && s_ready_o;
    assign slot_free_s = !m_valid_o || m_ready_i;
    assign k_s         = FILL_W'(cnt_q) + FILL_W'(accept_s);
    assign drain_s     = active_s && m_valid_o && m_ready_i && !load_s;

    // Vector as it would close this cycle: the incoming sample lands first, lanes >= k are zero.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (accept_s && (cnt_q == CNT_W'(i))) begin
                vec_s[i] = s_data_i;
            end else if (FILL_W'(i) < k_s) begin
                vec_s[i] = buf_q[i];
            end else begin
                vec_s[i] = '0;
            end
        end
    end

    // Next-state logic for the fill buffer and FILL/FULL control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        buf_d       = buf_q;
        load_s      = 1'b0;
        load_data_s = vec_s;
        load_fill_s = k_s;
        close_s     = 1'b0;
        if (clear_i) begin
            state_d = FILL;
            cnt_d   = '0;
        end else if (!en_i) begin
            state_d = state_q;
        end else begin
            case (state_q)
                FILL: begin
                    close_s = (accept_s && (cnt_q == LAST)) || (flush_i && (k_s != '0));
                    if (close_s) begin
                        if (slot_free_s) begin
                            load_s = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            state_d = FULL;
                            buf_d   = vec_s;
                            hold_d  = k_s;
                        end
                    end else if (accept_s) begin
                        buf_d[cnt_q] = s_data_i;
                        cnt_d        = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                FULL: begin
                    // Closed vector (already zero-padded) waits here for the slot.
                    if (slot_free_s) begin
                        load_s      = 1'b1;
                        load_data_s = buf_q;
                        load_fill_s = hold_q;
                        state_d     = FILL;
                        cnt_d       = '0;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Fill buffer and control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            hold_q  <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            buf_q   <= buf_d;
        end
    end

    energy_vec_slot #(
        .N      (N),
        .DATAW  (DATAW),
        .FILL_W (FILL_W)
    ) u_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .load_i  (load_s),
        .drain_i (drain_s),
        .data_i  (load_data_s),
        .fill_i  (load_fill_s),
        .valid_o (m_valid_o),
        .data_o  (m_data_o),
        .fill_o  (m_fill_o)
    );

endmodule

// File: tb/tb_energy_sample_collector.sv
// Randomized scoreboard bench for energy_sample_collector (N=4, DATAW=16).
module tb_energy_sample_collector;

    localparam int N     = 4;
    localparam int DATAW = 16;

    typedef struct packed {
        logic [3:0][15:0] lanes;
        logic [2:0]       fill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en, clr, flush, s_valid, m_ready;
    logic [15:0] s_data;
    logic        s_ready, m_valid;
    logic [15:0] m_data [N-1:0];
    logic [2:0]  m_fill;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t exp_q [$];
    logic [15:0] part [$];
    int   n_out = 0;

    always #5 clk = ~clk;

    energy_sample_collector #(.N(N), .DATAW(DATAW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .clear_i   (clr),
        .flush_i   (flush),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .m_fill_o  (m_fill)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One clock of stimulus; the reference model counts outstanding vectors and
    // keeps the partial vector as a list of samples.
    task automatic cyc(input bit e, input bit c, input bit f, input bit v,
                       input logic [15:0] d, input bit r);
        bit   exp_ready, consume, have_new, do_clear;
        vec_t nv;
        @(negedge clk);
        en = e; clr = c; flush = f; s_valid = v; s_data = d; m_ready = r;
        #1;
        exp_ready = e && !c && (n_out < 2);
        chk("s_ready", {63'd0, s_ready}, {63'd0, exp_ready});
        have_new = 1'b0;
        do_clear = 1'b0;
        nv       = '0;
        if (c) begin
            part.delete();
            n_out    = 0;
            do_clear = 1'b1;
        end else if (e) begin
            consume = (n_out > 0) && r;
            if (n_out == 2) begin
                if (consume) n_out = 1;
            end else begin
                if (v) part.push_back(d);
                if (part.size() == N || (f && part.size() > 0)) begin
                    foreach (part[i]) nv.lanes[i] = part[i];
                    nv.fill = 3'(part.size());
                    part.delete();
                    have_new = 1'b1;
                    n_out++;
                end
                if (consume) n_out--;
            end
        end
        @(posedge clk);
        if (do_clear) exp_q.delete();
        if (have_new) exp_q.push_back(nv);
        if (do_clear) begin
            #1;
            chk("clear_valid", {63'd0, m_valid}, 64'd0);
            chk("clear_fill", {61'd0, m_fill}, 64'd0);
        end
    endtask

    // Monitor: checks valid against the scoreboard and pops on every consumed vector.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("m_valid", {63'd0, m_valid}, {63'd0, exp_q.size() != 0});
                if (m_valid && m_ready && en && !clr) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_empty", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", {m_data[3], m_data[2], m_data[1], m_data[0]}, e.lanes);
                        chk("m_fill", {61'd0, m_fill}, {61'd0, e.fill});
                    end
                end
            end
        end
    end

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                16'($urandom), $urandom_range(0, 9) < 6);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; flush = 1'b0;
        s_valid = 1'b0; s_data = 16'd0; m_ready = 1'b0;
        #12;
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_fill", {61'd0, m_fill}, 64'd0);
        chk("rst_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_data", {m_data[3], m_data[2], m_data[1], m_data[0]}, 64'd0);
        #5 rst = 1'b0;

        // Back-to-back stream with the consumer ready.
        cyc(1, 0, 0, 1, 16'd5, 1);
        cyc(1, 0, 0, 1, 16'd9, 1);
        cyc(1, 0, 0, 1, 16'd2, 1);
        cyc(1, 0, 0, 1, 16'd7, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);

        // Back-pressure: second vector parks in the fill buffer.
        for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 1, 16'(i), 0);
        cyc(1, 0, 0, 1, 16'd99, 0);
        cyc(1, 0, 0, 0, 16'd0, 1);
        cyc(1, 0, 0, 1, 16'd11, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);

        // Early close with a same-cycle sample, then a flush with nothing buffered.
        cyc(1, 0, 0, 1, 16'd3, 1);
        cyc(1, 0, 0, 1, 16'd4, 1);
        cyc(1, 0, 1, 1, 16'd6, 1);
        cyc(1, 0, 1, 0, 16'd0, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);

        // Enable low mid-vector with a pending output and a ready consumer.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 16'(16'h20 + i), 0);
        cyc(1, 0, 0, 1, 16'h30, 0);
        cyc(1, 0, 0, 1, 16'h31, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 16'h77, 1);
        cyc(1, 0, 0, 1, 16'h32, 1);
        cyc(1, 0, 0, 1, 16'h33, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);

        // Clear with a partial vector and a pending output.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 16'(16'h40 + i), 0);
        cyc(1, 0, 0, 1, 16'h50, 0);
        cyc(1, 0, 0, 1, 16'h51, 0);
        cyc(1, 1, 0, 1, 16'h52, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 16'(16'h60 + i), 1);
        cyc(1, 0, 0, 0, 16'd0, 1);

        rand_cycles(3000);

        // Asynchronous reset in the middle of a fill.
        cyc(1, 0, 0, 1, 16'h81, 0);
        cyc(1, 0, 0, 1, 16'h82, 0);
        @(negedge clk);
        en = 1'b1; s_valid = 1'b1; s_data = 16'h83; m_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, m_valid}, 64'd0);
        chk("arst_fill", {61'd0, m_fill}, 64'd0);
        chk("arst_ready", {63'd0, s_ready}, 64'd0);
        part.delete();
        n_out = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 16'(16'h90 + i), 1);
        cyc(1, 0, 0, 0, 16'd0, 1);

        rand_cycles(1000);
        cyc(1, 0, 0, 0, 16'd0, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);
        cyc(1, 0, 0, 0, 16'd0, 1);
        @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
